alu_pipe_mse: RTL and testbench
===============================

Name: alu_pipe_mse

Overview:
- Parametrised, two-stage pipelined ALU with a valid/ready handshake on input and output.
- Adds four registered flags and a completed-operation counter.
- Carries the team's mutation-testing scheme forward as a compile-time module-substitution fault injector.
- Sits between the stimulus sequencer and the scoreboard in the ALU mutation-testing harness.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode presented
in_ready  output  1  block accepts operand this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_opcode  input  3  operation select
out_valid  output  1  result presented
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_zero  output  1  result == 0
out_carry  output  1  ADD carry-out / SUB borrow
out_ovf  output  1  signed overflow (ADD/SUB only)
out_neg  output  1  result MSB
op_count  output  CNT_W  count of completed output transfers

Behaviour:
- Reset (rst_n low, async): all outputs 0, stage valids 0, op_count 0; out_zero also 0. In-flight data is discarded. in_ready is 1 from the first clock edge after rst_n deasserts.
- Clock and reset: one clock `clk`, rising edge. Reset `rst_n` is asynchronous, active-low; this polarity and synchronicity are fixed.
- Pipeline:
  - S1 registers a, b, opcode (plus mse_sel when enabled).
  - S2 computes the result and registers result and flags into the output register.
  - Latency: 2 cycles from input acceptance to out_valid, with no stall.
- Handshake:
  - Transfer occurs when valid && ready, on either side.
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready (combinational chain; no skid buffer).
  - out_* is held stable while out_valid && !out_ready.
  - Throughput is 1 op/cycle when out_ready is held high.
  - Maximum occupancy is 2 transactions; order is preserved and none are dropped or duplicated.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 000 ADD: A+B; carry = carry-out; ovf = signed overflow.
  - 001 SUB: A−B; carry = 1 when A<B unsigned (borrow); ovf = signed overflow.
  - 010 AND, 011 OR, 100 XOR: bitwise; carry = ovf = 0.
  - 101 EQ: result = 1 if A==B, else 0 (zero-extended).
  - 110 LT: unsigned A<B gives 1, else 0.
  - 111 NOP: result 0.
  - For all opcodes: zero = (result==0); neg = result[WIDTH−1]. EQ, LT, logic and NOP force carry = ovf = 0.
- op_count:
  - Increments by 1 on each out_valid && out_ready cycle, NOP included.
  - Wraps from 2^CNT_W−1 to 0.
  - Not affected by input-side transfers.
- Simultaneous events:
  - A new input may be accepted in the same cycle the output drains. Both occur; occupancy is unchanged.
  - A reset assertion overrides any transfer in that cycle.

Optional Feature:
- Macro: ALU_MSE_INJECT_EN
- When defined:
  - Adds port `mse_sel  input  2`. It is sampled with the operand at input acceptance and travels with its transaction.
  - 00: golden behaviour.
  - 01: AND opcode computes A|B.
  - 10: OR opcode computes A&B.
  - 11: XOR opcode computes A&B.
  - Flags are derived from the substituted result.
  - Other opcodes are never affected.
- When undefined: no mse_sel port; golden behaviour only; no injection logic synthesised.

Test Plan:
- Reset then WIDTH=8 ADD 0xFF+0x01, out_ready=1 -> 2 cycles later out_result=0x00, zero=1, carry=1, ovf=0, neg=0, op_count=1.
- SUB 0x80−0x01 -> 0x7F, ovf=1, carry=0, neg=0. SUB 0x03−0x05 -> 0xFE, carry=1, neg=1.
- out_ready=0, drive 3 back-to-back ADDs -> in_ready low after 2 accepted; raise out_ready -> results emerge in order, none lost, op_count=3.
- Assert rst_n low with 2 ops in flight -> out_valid=0 and op_count=0 immediately (async); in_ready=1 after release; no stale result ever appears.
- ALU_MSE_INJECT_EN, mse_sel=01, AND 0x0C,0x0A -> 0x0E (golden 0x08). mse_sel=11, XOR 0x0F,0x0F -> 0x0F, zero=0 (golden 0x00, zero=1).
- CNT_W=4: 16 completed transfers -> op_count wraps to 0; EQ 0x55,0x55 -> 0x01 and LT 0x05,0x03 -> 0x00, zero=1.

Source files
------------

// File: rtl/alu_pipe_mse.sv
// alu_pipe_mse -- two-stage pipelined ALU with valid/ready on both sides.
//
// Optional feature macro: ALU_MSE_INJECT_EN (adds mse_sel fault-substitution input).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_a, in_b, in_opcode sampled on transfer
//   mse_sel               (ALU_MSE_INJECT_EN only) substitution select, travels with op
//   out_valid/out_ready   output handshake; out_result and flags held while stalled
//   out_zero/carry/ovf/neg  registered result flags
//   op_count              completed output transfers, wraps modulo 2^CNT_W
module alu_pipe_mse #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_opcode,
`ifdef ALU_MSE_INJECT_EN
    input  logic [1:0]       mse_sel,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_neg,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_EQ  = 3'b101,
        OP_LT  = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    localparam int MSB = WIDTH - 1;

    // Stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    op_e              s1_op_q;
`ifdef ALU_MSE_INJECT_EN
    logic [1:0]       s1_sel_q;
`endif

    // Output register
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, carry_q, ovf_q, neg_q;
    logic [CNT_W-1:0] cnt_q;

    // Held low through reset and set on the first edge after release, so
    // in_ready reads 0 during reset and 1 from the first clock onward.
    logic             rdy_en_q;

    logic s2_ready, in_fire, s1_fire, out_fire;

    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = rdy_en_q && (!s1_valid_q || s2_ready);
    assign in_fire  = in_valid && in_ready;
    assign s1_fire  = s1_valid_q && s2_ready;
    assign out_fire = out_valid_q && out_ready;

    // Stage 2 combinational compute
    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH-1:0] and_w, or_w, xor_w;
    logic [WIDTH-1:0] res_d;
    logic             carry_d, ovf_d;

    assign sum_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};

`ifdef ALU_MSE_INJECT_EN
    assign and_w = (s1_sel_q == 2'b01) ? (s1_a_q | s1_b_q) : (s1_a_q & s1_b_q);
    assign or_w  = (s1_sel_q == 2'b10) ? (s1_a_q & s1_b_q) : (s1_a_q | s1_b_q);
    assign xor_w = (s1_sel_q == 2'b11) ? (s1_a_q & s1_b_q) : (s1_a_q ^ s1_b_q);
`else
    assign and_w = s1_a_q & s1_b_q;
    assign or_w  = s1_a_q | s1_b_q;
    assign xor_w = s1_a_q ^ s1_b_q;
`endif

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        unique case (s1_op_q)
            OP_ADD: begin
                res_d   = sum_w[WIDTH-1:0];
                carry_d = sum_w[WIDTH];
                ovf_d   = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum_w[MSB] != s1_a_q[MSB]);
            end
            OP_SUB: begin
                res_d   = diff_w[WIDTH-1:0];
                carry_d = diff_w[WIDTH]; // borrow: A < B unsigned
                ovf_d   = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff_w[MSB] != s1_a_q[MSB]);
            end
            OP_AND:  res_d = and_w;
            OP_OR:   res_d = or_w;
            OP_XOR:  res_d = xor_w;
            OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (s1_a_q == s1_b_q)};
            OP_LT:   res_d = {{(WIDTH-1){1'b0}}, (s1_a_q < s1_b_q)};
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
`ifdef ALU_MSE_INJECT_EN
            s1_sel_q   <= '0;
`endif
        end else begin
            rdy_en_q <= 1'b1;
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= in_a;
                s1_b_q     <= in_b;
                s1_op_q    <= op_e'(in_opcode);
`ifdef ALU_MSE_INJECT_EN
                s1_sel_q   <= mse_sel;
`endif
            end else if (s1_fire) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
        end else if (s1_fire) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
            zero_q      <= (res_d == '0);
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            neg_q       <= res_d[MSB];
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_fire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_zero   = zero_q;
    assign out_carry  = carry_q;
    assign out_ovf    = ovf_q;
    assign out_neg    = neg_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_pipe_mse.sv
// tb_alu_pipe_mse -- directed self-checking bench for alu_pipe_mse
// (WIDTH=8, CNT_W=4 so the counter wrap is reachable quickly).
module tb_alu_pipe_mse;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic [2:0] in_opcode;
`ifdef ALU_MSE_INJECT_EN
    logic [1:0] mse_sel;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_zero, out_carry, out_ovf, out_neg;
    logic [3:0] op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_pipe_mse #(.WIDTH(8), .CNT_W(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
`ifdef ALU_MSE_INJECT_EN
        .mse_sel    (mse_sel),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_neg    (out_neg),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One op through an empty pipeline with out_ready high.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [7:0] er,
                          input logic ez, input logic ec, input logic eo, input logic en);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_opcode = op; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, " in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 1);
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " result"}, out_result, er);
        check({tag, " zero"}, out_zero, ez);
        check({tag, " carry"}, out_carry, ec);
        check({tag, " ovf"}, out_ovf, eo);
        check({tag, " neg"}, out_neg, en);
        check({tag, " cnt_before"}, op_count, exp_cnt % 16);
        @(negedge clk);
        exp_cnt++;
        check({tag, " cnt_after"}, op_count, exp_cnt % 16);
        check({tag, " drained"}, out_valid, 0);
    endtask

    logic [7:0] bp_a [3] = '{8'h10, 8'h7F, 8'hC0};
    logic [7:0] bp_b [3] = '{8'h20, 8'h01, 8'h50};
    logic [7:0] bp_r [3] = '{8'h30, 8'h80, 8'h10};

    initial begin
        int idx, got;
        logic acc;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; out_ready = 1'b0;
`ifdef ALU_MSE_INJECT_EN
        mse_sel = 2'b00;
`endif
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 0);
        check("rst op_count", op_count, 0);
        check("rst out_zero", out_zero, 0);
        check("rst out_result", out_result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rel in_ready pre-edge", in_ready, 0);
        @(posedge clk);
        #1 check("rel in_ready", in_ready, 1);

        //        tag        a      b      op     res    z  c  o  n
        run_op("add ff+01", 8'hFF, 8'h01, 3'b000, 8'h00, 1, 1, 0, 0);
        run_op("sub 80-01", 8'h80, 8'h01, 3'b001, 8'h7F, 0, 0, 1, 0);
        run_op("sub 03-05", 8'h03, 8'h05, 3'b001, 8'hFE, 0, 1, 0, 1);
        run_op("add 7f+01", 8'h7F, 8'h01, 3'b000, 8'h80, 0, 0, 1, 1);
        run_op("sub 05-05", 8'h05, 8'h05, 3'b001, 8'h00, 1, 0, 0, 0);
        run_op("and 0c 0a", 8'h0C, 8'h0A, 3'b010, 8'h08, 0, 0, 0, 0);
        run_op("and f0 ff", 8'hF0, 8'hFF, 3'b010, 8'hF0, 0, 0, 0, 1);
        run_op("or 0c 0a",  8'h0C, 8'h0A, 3'b011, 8'h0E, 0, 0, 0, 0);
        run_op("xor 0f 0f", 8'h0F, 8'h0F, 3'b100, 8'h00, 1, 0, 0, 0);
        run_op("eq 55 55",  8'h55, 8'h55, 3'b101, 8'h01, 0, 0, 0, 0);
        run_op("eq 55 54",  8'h55, 8'h54, 3'b101, 8'h00, 1, 0, 0, 0);
        run_op("lt 05 03",  8'h05, 8'h03, 3'b110, 8'h00, 1, 0, 0, 0);
        run_op("lt 03 05",  8'h03, 8'h05, 3'b110, 8'h01, 0, 0, 0, 0);
        run_op("nop ff ff", 8'hFF, 8'hFF, 3'b111, 8'h00, 1, 0, 0, 0);

`ifdef ALU_MSE_INJECT_EN
        mse_sel = 2'b01;
        run_op("inj01 and", 8'h0C, 8'h0A, 3'b010, 8'h0E, 0, 0, 0, 0);
        run_op("inj01 add", 8'hFF, 8'h01, 3'b000, 8'h00, 1, 1, 0, 0);
        mse_sel = 2'b10;
        run_op("inj10 or",  8'h0C, 8'h0A, 3'b011, 8'h08, 0, 0, 0, 0);
        mse_sel = 2'b11;
        run_op("inj11 xor", 8'h0F, 8'h0F, 3'b100, 8'h0F, 0, 0, 0, 0);
        run_op("inj11 and", 8'h0C, 8'h0A, 3'b010, 8'h08, 0, 0, 0, 0);
        mse_sel = 2'b00;
`endif

        // Back-pressure: three ADDs against a stalled consumer.
        idx = 0; got = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            if (idx < 3) begin
                in_valid = 1'b1; in_a = bp_a[idx]; in_b = bp_b[idx]; in_opcode = 3'b000;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 3) begin
                check("bp accepted", idx, 2);
                check("bp in_ready low", in_ready, 0);
                check("bp held valid", out_valid, 1);
                check("bp held result", out_result, bp_r[0]);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (got < 3) check($sformatf("bp result %0d", got), out_result, bp_r[got]);
                got++;
                exp_cnt++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp drained count", got, 3);
        check("bp op_count", op_count, exp_cnt % 16);

        // Counter wrap: enough NOPs to cross 15 -> 0 on the 4-bit counter.
        for (int i = 0; i < 18; i++)
            run_op("wrap nop", 8'h00, 8'h00, 3'b111, 8'h00, 1, 0, 0, 0);

        // Reset with two ops in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_opcode = 3'b000; in_a = 8'h01; in_b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        in_a = 8'h02; in_b = 8'h02;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("pre-rst out_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst op_count", op_count, 0);
        check("async rst in_ready", in_ready, 0);
        check("async rst result", out_result, 0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 check("post-rst in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("no stale %0d", i), out_valid, 0);
        end
        run_op("post-rst add", 8'h03, 8'h04, 3'b000, 8'h07, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
